ast_to_bt656: RTL

// Avalon-ST video sink -> BT.656 (625-line, 27 MHz, 8-bit) byte stream generator; transmit counterpart of the BT.656 capture path.

---
 rtl/ast_to_bt656.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/ast_to_bt656.sv
// Avalon-ST video sink to BT.656 625-line byte stream. A free-running PAL timing generator
// emits EAV/SAV/blanking; active bytes are pulled from the sink only during active slots.
module ast_to_bt656 #(
  parameter int unsigned LINE_WIDTH  = 720,
  parameter int unsigned BLANK_WIDTH = 280,
  parameter int unsigned HALF_HEIGHT = 288
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [7:0] din_data,
  input  logic       din_valid,
  input  logic       din_startofpacket,
  input  logic       din_endofpacket,
  output logic       din_ready,
  output logic [7:0] bt_data,
  output logic       underrun,
  output logic       len_error,
  input  logic       status_clear
);

  localparam int unsigned HTotal  = 8 + BLANK_WIDTH + 2 * LINE_WIDTH;
  localparam logic [10:0] HSav    = 11'(4 + BLANK_WIDTH);
  localparam logic [10:0] HAct    = 11'(8 + BLANK_WIDTH);
  localparam logic [10:0] HLast   = 11'(HTotal - 1);
  localparam logic [18:0] PixLast = 19'(HALF_HEIGHT * 2 * LINE_WIDTH - 1);

  typedef enum logic [2:0] {PIdle, PCtrl, PArmed, PStream, PDiscard} state_e;

  state_e      state_q, state_d;
  logic [10:0] h_q, h_d;
  logic [9:0]  line_q, line_d;
  logic [18:0] pix_q, pix_d;
  logic [3:0]  ctrl_cnt_q, ctrl_cnt_d;
  logic        tgt_any_q, tgt_any_d, tgt_f_q, tgt_f_d;
  logic        stream_f_q, stream_f_d, done_q, done_d;
  logic        run_q;
  logic [7:0]  bt_q, bt_d;
  logic        underrun_q, underrun_d, len_error_q, len_error_d;

  logic       f_cur, v_cur, line_act, in_eav, in_sav, act_slot, stream_slot;
  logic       ready_c, xfer, emit, ur_set, le_set, pix_last;
  logic [1:0] code_idx;

  function automatic logic [7:0] xy(input logic f, input logic v, input logic h);
    return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
  endfunction

  // Packet type from the SOP byte; a single-byte packet ends immediately.
  function automatic state_e dispatch(input logic [7:0] d, input logic eop);
    if (eop)               return PIdle;
    if (d[3:0] == 4'hF)    return PCtrl;
    if (d == 8'h00)        return PArmed;
    return PDiscard;
  endfunction

  assign f_cur       = (line_q >= 10'd313);
  assign v_cur       = (line_q <= 10'd22) || (line_q >= 10'd311 && line_q <= 10'd335) ||
                       (line_q >= 10'd624);
  assign line_act    = (line_q >= 10'd23 && line_q <= 10'd310) ||
                       (line_q >= 10'd336 && line_q <= 10'd623);
  assign in_eav      = (h_q < 11'd4);
  assign in_sav      = (h_q >= HSav) && (h_q < HAct);
  assign act_slot    = line_act && (h_q >= HAct);
  assign stream_slot = act_slot && (f_cur == stream_f_q);
  assign code_idx    = in_eav ? h_q[1:0] : 2'(h_q - HSav);
  assign pix_last    = (pix_q == PixLast);

  always_comb begin
    unique case (state_q)
      PIdle, PCtrl, PDiscard: ready_c = 1'b1;
      PStream:                ready_c = stream_slot && !done_q;
      default:                ready_c = 1'b0;
    endcase
  end

  assign din_ready = run_q & ready_c;
  assign xfer      = din_valid & din_ready;

  always_comb begin
    h_d    = h_q + 11'd1;
    line_d = line_q;
    if (h_q == HLast) begin
      h_d    = '0;
      line_d = (line_q == 10'd625) ? 10'd1 : line_q + 10'd1;
    end
  end

  always_comb begin
    state_d    = state_q;
    pix_d      = pix_q;
    ctrl_cnt_d = ctrl_cnt_q;
    tgt_any_d  = tgt_any_q;
    tgt_f_d    = tgt_f_q;
    stream_f_d = stream_f_q;
    done_d     = done_q;
    emit       = 1'b0;
    ur_set     = 1'b0;
    le_set     = 1'b0;
    unique case (state_q)
      PIdle: begin
        if (xfer && din_startofpacket) begin
          state_d    = dispatch(din_data, din_endofpacket);
          ctrl_cnt_d = 4'd1;
        end
      end
      PCtrl: begin
        if (xfer && din_startofpacket) begin
          state_d    = dispatch(din_data, din_endofpacket);
          ctrl_cnt_d = 4'd1;
        end else if (xfer) begin
          if (ctrl_cnt_q == 4'd9) begin
            tgt_any_d = 1'b1;
            if (din_data[3:0] == 4'b1011) begin
              tgt_any_d = 1'b0;
              tgt_f_d   = 1'b0;
            end else if (din_data[3:0] == 4'b1111) begin
              tgt_any_d = 1'b0;
              tgt_f_d   = 1'b1;
            end
          end
          if (ctrl_cnt_q != 4'hF) ctrl_cnt_d = ctrl_cnt_q + 4'd1;
          if (din_endofpacket) state_d = PIdle;
        end
      end
      PArmed: begin
        // Arm on the last SAV byte so the first active slot is already streaming.
        if (h_q == HSav + 11'd3 &&
            ((line_q == 10'd23 && (tgt_any_q || !tgt_f_q)) ||
             (line_q == 10'd336 && (tgt_any_q || tgt_f_q)))) begin
          state_d    = PStream;
          stream_f_d = f_cur;
          pix_d      = '0;
          done_d     = 1'b0;
          tgt_any_d  = 1'b1;
        end
      end
      PStream: begin
        if (stream_slot) begin
          pix_d = pix_q + 19'd1;
          if (done_q) begin
            if (pix_last) state_d = PIdle;
          end else if (xfer && din_startofpacket) begin
            le_set     = 1'b1;
            state_d    = dispatch(din_data, din_endofpacket);
            ctrl_cnt_d = 4'd1;
          end else if (xfer) begin
            emit = 1'b1;
            if (pix_last) begin
              le_set  = !din_endofpacket;
              state_d = din_endofpacket ? PIdle : PDiscard;
            end else if (din_endofpacket) begin
              le_set = 1'b1;
              done_d = 1'b1;
            end
          end else begin
            ur_set = 1'b1;
            if (pix_last) begin
              le_set  = 1'b1;
              state_d = PDiscard;
            end
          end
        end
      end
      PDiscard: begin
        if (xfer && din_endofpacket) state_d = PIdle;
      end
      default: state_d = PIdle;
    endcase
  end

  always_comb begin
    if (in_eav || in_sav) begin
      unique case (code_idx)
        2'd0:    bt_d = 8'hFF;
        2'd3:    bt_d = xy(f_cur, v_cur, in_eav);
        default: bt_d = 8'h00;
      endcase
    end else if (emit) begin
      bt_d = din_data;
    end else begin
      bt_d = h_q[0] ? 8'h10 : 8'h80;
    end
    underrun_d  = (underrun_q & ~status_clear) | ur_set;
    len_error_d = (len_error_q & ~status_clear) | le_set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= PIdle;
      h_q         <= '0;
      line_q      <= 10'd1;
      pix_q       <= '0;
      ctrl_cnt_q  <= '0;
      tgt_any_q   <= 1'b1;
      tgt_f_q     <= 1'b0;
      stream_f_q  <= 1'b0;
      done_q      <= 1'b0;
      run_q       <= 1'b0;
      bt_q        <= 8'h80;
      underrun_q  <= 1'b0;
      len_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      line_q      <= line_d;
      pix_q       <= pix_d;
      ctrl_cnt_q  <= ctrl_cnt_d;
      tgt_any_q   <= tgt_any_d;
      tgt_f_q     <= tgt_f_d;
      stream_f_q  <= stream_f_d;
      done_q      <= done_d;
      run_q       <= 1'b1;
      bt_q        <= bt_d;
      underrun_q  <= underrun_d;
      len_error_q <= len_error_d;
    end
  end

  assign bt_data   = bt_q;
  assign underrun  = underrun_q;
  assign len_error = len_error_q;

endmodule
